ctrl_seq: RTL and testbench

Multi-cycle control sequencer for the 8-bit datapath. It fetches instruction words from the program ROM, holds them in an instruction register, and decodes them into per-cycle control for the data memory, register file and ALU: memory address/source select, memory write enable, and register write enable. It sits directly upstream of the data memory and produces its `addr_id`, `a_source` and `ce` inputs.

---
 rtl/ctrl_seq.sv | 76 +++++++
 tb/tb_ctrl_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle FETCH/EXEC sequencer driving data memory, register file and ALU control.
module ctrl_seq #(
    parameter int WIDTH    = 8,
    parameter int A_WIDTH  = 10,
    parameter int PC_WIDTH = 8,
    parameter int IW       = 8 + A_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    output logic [PC_WIDTH-1:0] instr_addr,
    input  logic [IW-1:0]       instr_data,
    input  logic                zero_flag,
    output logic [A_WIDTH-1:0]  mem_addr_id,
    output logic [1:0]          mem_a_source,
    output logic                mem_ce,
    output logic                rf_we,
    output logic [1:0]          rf_waddr,
    output logic [1:0]          rf_raddr,
    output logic [1:0]          alu_op,
    output logic [WIDTH-1:0]    imm_out,
    output logic                halted
);
    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [IW-1:0]       r_ir;

    logic [3:0]         w_op;
    logic [1:0]         w_src;
    logic [1:0]         w_rd;
    logic [A_WIDTH-1:0] w_imm;
    logic               w_exec;
    logic               w_jump;

    assign w_op   = r_ir[IW-1 -: 4];
    assign w_src  = r_ir[IW-5 -: 2];
    assign w_rd   = r_ir[IW-7 -: 2];
    assign w_imm  = r_ir[A_WIDTH-1:0];
    assign w_exec = r_state == EXEC;
    assign w_jump = w_op == 4'd5 || (w_op == 4'd6 && zero_flag);

    // Enables depend only on state, so an async reset drops them at once.
    assign mem_ce       = w_exec && w_op == 4'd2 && w_src[0];
    assign rf_we        = w_exec && (w_op == 4'd1 || w_op == 4'd3 || w_op == 4'd4);
    assign alu_op       = w_op == 4'd3 ? 2'b01 : w_op == 4'd4 ? 2'b10 : 2'b00;
    assign mem_a_source = w_src;
    assign mem_addr_id  = w_imm;
    assign imm_out      = w_imm[WIDTH-1:0];
    assign rf_waddr     = w_rd;
    assign rf_raddr     = w_rd;
    assign instr_addr   = r_pc;
    assign halted       = r_state == HALT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            case (r_state)
                FETCH: if (run) begin
                    r_ir    <= instr_data;
                    r_pc    <= r_pc + 1'b1;
                    r_state <= EXEC;
                end
                EXEC: begin
                    if (w_jump) r_pc <= w_imm[PC_WIDTH-1:0];
                    r_state <= w_op == 4'hF ? HALT : FETCH;
                end
                default: r_state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed self-checking bench for ctrl_seq with a behavioural ROM.
module tb_ctrl_seq;
    logic        clk;
    logic        rst_n;
    logic        run;
    logic [7:0]  instr_addr;
    logic [17:0] instr_data;
    logic        zero_flag;
    logic [9:0]  mem_addr_id;
    logic [1:0]  mem_a_source;
    logic        mem_ce;
    logic        rf_we;
    logic [1:0]  rf_waddr;
    logic [1:0]  rf_raddr;
    logic [1:0]  alu_op;
    logic [7:0]  imm_out;
    logic        halted;

    logic [17:0] rom [256];
    int n_checks = 0;
    int n_fail   = 0;

    ctrl_seq dut (
        .clk(clk), .rst_n(rst_n), .run(run), .instr_addr(instr_addr),
        .instr_data(instr_data), .zero_flag(zero_flag), .mem_addr_id(mem_addr_id),
        .mem_a_source(mem_a_source), .mem_ce(mem_ce), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_raddr(rf_raddr), .alu_op(alu_op),
        .imm_out(imm_out), .halted(halted)
    );

    assign instr_data = rom[instr_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] ins(input logic [3:0] op, input logic [1:0] src,
                                        input logic [1:0] rd, input logic [9:0] imm);
        return {op, src, rd, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_rom();
        foreach (rom[i]) rom[i] = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        run = 1'b0;
        zero_flag = 1'b0;
        clr_rom();
        rom[0] = ins(4'd2, 2'b01, 2'd0, 10'h3FF);
        step(2);
        check("rst_addr", instr_addr, 0);
        check("rst_addr_id", mem_addr_id, 0);
        check("rst_imm", imm_out, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_raddr", rf_raddr, 0);
        check("rst_src", mem_a_source, 0);
        check("rst_alu", alu_op, 0);
        check("rst_ce", mem_ce, 0);
        check("rst_we", rf_we, 0);
        check("rst_halt", halted, 0);

        // reset dropped mid-EXEC of a store
        rst_n = 1'b1;
        run = 1'b1;
        step(1);
        check("st_ce", mem_ce, 1);
        check("st_src", mem_a_source, 1);
        check("st_addr_id", mem_addr_id, 10'h3FF);
        check("st_pc", instr_addr, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstx_ce", mem_ce, 0);
        check("rstx_pc", instr_addr, 0);
        check("rstx_addr_id", mem_addr_id, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        check("rstx_refetch_ce", mem_ce, 1);
        check("rstx_refetch_pc", instr_addr, 1);

        // LD / ADD / HALT
        clr_rom();
        rom[0] = ins(4'd1, 2'b00, 2'd1, 10'h005);
        rom[1] = ins(4'd3, 2'b00, 2'd1, 10'h000);
        rom[2] = ins(4'hF, 2'b00, 2'd0, 10'h000);
        do_reset();
        run = 1'b1;
        step(1);
        check("ld_we", rf_we, 1);
        check("ld_alu", alu_op, 0);
        check("ld_waddr", rf_waddr, 1);
        check("ld_imm", imm_out, 8'h05);
        step(1);
        check("ld_we_off", rf_we, 0);
        check("ld_fetch_pc", instr_addr, 1);
        step(1);
        check("add_we", rf_we, 1);
        check("add_alu", alu_op, 1);
        check("add_raddr", rf_raddr, 1);
        check("add_waddr", rf_waddr, 1);
        step(1);
        check("add_we_off", rf_we, 0);
        step(1);
        check("halt_exec", halted, 0);
        step(1);
        check("halt_set", halted, 1);
        check("halt_we", rf_we, 0);
        check("halt_pc", instr_addr, 3);
        step(4);
        check("halt_stay", halted, 1);
        check("halt_pc_stay", instr_addr, 3);
        check("halt_ce", mem_ce, 0);

        // JZ taken and not taken
        for (int z = 1; z >= 0; z--) begin
            clr_rom();
            rom[3] = ins(4'd6, 2'b00, 2'd0, 10'h010);
            do_reset();
            zero_flag = z[0];
            run = 1'b1;
            step(7);
            check("jz_exec_pc", instr_addr, 4);
            step(1);
            check(z ? "jz_taken" : "jz_not_taken", instr_addr, z ? 32'h10 : 32'h4);
        end
        zero_flag = 1'b0;

        // PC wrap via JMP to 0xFF then NOP
        clr_rom();
        rom[0] = ins(4'd5, 2'b00, 2'd0, 10'h0FF);
        do_reset();
        run = 1'b1;
        step(2);
        check("jmp_pc", instr_addr, 8'hFF);
        step(1);
        check("wrap_exec", instr_addr, 0);
        step(1);
        check("wrap_fetch", instr_addr, 0);

        // run gating and source checks
        clr_rom();
        rom[0] = ins(4'd1, 2'b00, 2'd2, 10'h007);
        rom[1] = ins(4'd2, 2'b11, 2'd2, 10'h02A);
        rom[2] = ins(4'd2, 2'b00, 2'd1, 10'h005);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("gate_pc", instr_addr, 0);
            check("gate_we", rf_we, 0);
            check("gate_ce", mem_ce, 0);
            check("gate_ir", imm_out, 0);
        end
        run = 1'b1;
        step(1);
        check("gate_ld_we", rf_we, 1);
        check("gate_ld_imm", imm_out, 8'h07);
        run = 1'b0;
        step(1);
        check("gate_done_we", rf_we, 0);
        check("gate_done_pc", instr_addr, 1);
        step(1);
        check("gate_hold_pc", instr_addr, 1);
        check("gate_hold_ir", imm_out, 8'h07);
        run = 1'b1;
        step(1);
        check("ind_src", mem_a_source, 3);
        check("ind_ce", mem_ce, 1);
        check("ind_addr_id", mem_addr_id, 10'h02A);
        check("ind_raddr", rf_raddr, 2);
        step(1);
        check("ind_ce_off", mem_ce, 0);
        step(1);
        check("imm_st_src", mem_a_source, 0);
        check("imm_st_ce", mem_ce, 0);
        check("imm_st_we", rf_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
